// File: rtl/cache_pkg.sv
// Shared definitions for the parameterised direct-mapped write-through cache:
// controller state encoding and default geometry.
package cache_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_INDEX_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WTHRU = 2'd2
   } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the direct-mapped cache: one valid bit, tag and data word
// per line, an asynchronous lookup port, one write port and a bulk invalidate.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int INDEX_W = DEF_INDEX_W,
   parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - 2,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic [INDEX_W-1:0] lk_index,
   input  logic [TAG_W-1:0]   lk_tag,
   output logic               lk_hit,
   output logic [DATA_W-1:0]  lk_data,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [DATA_W-1:0]  wr_data
);

   localparam int LINES = 2 ** INDEX_W;

   logic [LINES-1:0] valid_reg;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   // Valid bits: cleared by reset or flush, set by any line write.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid_reg <= '0;
      end else if (wr_en) begin
         valid_reg[wr_index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; the valid bit qualifies them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign lk_hit  = valid_reg[lk_index] && (tag_mem[lk_index] == lk_tag);
   assign lk_data = data_mem[lk_index];

endmodule

// File: rtl/param_cache.sv
// Direct-mapped, one-word-per-line, write-through / write-allocate cache.
// Read hits answer in one cycle; read misses fill from backing memory; all
// writes update the line at once and are written through to memory.
// Optional feature: define CACHE_STATS_EN to add saturating hit/miss counters.
module param_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int INDEX_W = DEF_INDEX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MWR,
   input  logic              MOE,
   input  logic [ADDR_W-1:0] Adr,
   input  logic [DATA_W-1:0] MWD,
   input  logic              flush,
   output logic              req_ready,
   output logic [DATA_W-1:0] CRD,
   output logic              rsp_valid,
   output logic              hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rd
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int TAG_W = ADDR_W - INDEX_W - 2;
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   state_t             state_reg;
   logic               flush_pend_reg;
   logic [INDEX_W-1:0] req_index_reg;
   logic [TAG_W-1:0]   req_tag_reg;
   logic               req_hit_reg;

   logic [INDEX_W-1:0] adr_index;
   logic [TAG_W-1:0]   adr_tag;
   logic               do_flush;
   logic               accept;
   logic               fill_done;
   logic               lk_hit;
   logic [DATA_W-1:0]  lk_data;
   logic               wr_en;
   logic [INDEX_W-1:0] wr_index;
   logic [TAG_W-1:0]   wr_tag;
   logic [DATA_W-1:0]  wr_data;

   assign adr_index = Adr[INDEX_W+1:2];
   assign adr_tag   = Adr[ADDR_W-1:INDEX_W+2];

   // A flush (fresh or deferred) takes the IDLE cycle and pushes any request back.
   assign do_flush  = (state_reg == IDLE) && (flush || flush_pend_reg);
   assign req_ready = (state_reg == IDLE) && !do_flush;
   assign accept    = (MWR || MOE) && req_ready;
   assign fill_done = (state_reg == FILL) && mem_ack;

   // Writes allocate on acceptance; fills install on the acknowledge edge.
   assign wr_en    = (accept && MWR) || fill_done;
   assign wr_index = fill_done ? req_index_reg : adr_index;
   assign wr_tag   = fill_done ? req_tag_reg   : adr_tag;
   assign wr_data  = fill_done ? mem_rd        : MWD;

   cache_line_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .clear    (do_flush),
      .lk_index (adr_index),
      .lk_tag   (adr_tag),
      .lk_hit   (lk_hit),
      .lk_data  (lk_data),
      .wr_en    (wr_en),
      .wr_index (wr_index),
      .wr_tag   (wr_tag),
      .wr_data  (wr_data)
   );

   // Controller: accept/lookup in IDLE, wait for memory in FILL/WTHRU, registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         flush_pend_reg <= 1'b0;
         req_index_reg  <= '0;
         req_tag_reg    <= '0;
         req_hit_reg    <= 1'b0;
         rsp_valid      <= 1'b0;
         hit            <= 1'b0;
         CRD            <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_adr        <= '0;
         mem_wd         <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (do_flush) begin
            flush_pend_reg <= 1'b0;
         end else if (flush) begin
            flush_pend_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  req_index_reg <= adr_index;
                  req_tag_reg   <= adr_tag;
                  req_hit_reg   <= lk_hit;
                  if (MWR) begin
                     state_reg <= WTHRU;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_adr   <= Adr & WORD_MASK;
                     mem_wd    <= MWD;
                  end else if (lk_hit) begin
                     rsp_valid <= 1'b1;
                     hit       <= 1'b1;
                     CRD       <= lk_data;
                  end else begin
                     state_reg <= FILL;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_adr   <= Adr & WORD_MASK;
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  state_reg <= IDLE;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  hit       <= 1'b0;
                  CRD       <= mem_rd;
               end
            end
            WTHRU: begin
               if (mem_ack) begin
                  state_reg <= IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  hit       <= req_hit_reg;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic done_now;
   logic done_hit;

   assign done_now = (accept && !MWR && lk_hit) || fill_done ||
                     ((state_reg == WTHRU) && mem_ack);
   assign done_hit = (accept && !MWR && lk_hit) ||
                     ((state_reg == WTHRU) && mem_ack && req_hit_reg);

   // Completed-request counters, saturating; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (done_now) begin
         if (done_hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
         end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter DATA_W, default 32: word width; one word per line.
REQ-003 Parameter INDEX_W, default 4: index bits; 2**INDEX_W direct-mapped lines.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 MWR  in  1  CPU write request.
REQ-007 MOE  in  1  CPU read request.
REQ-008 Adr  in  ADDR_W  byte address; Adr[1:0] ignored.
REQ-009 MWD  in  DATA_W  CPU write data.
REQ-010 flush  in  1  invalidate all lines.
REQ-011 req_ready  out  1  high only in IDLE; a request is accepted when (MWR|MOE)&req_ready.
REQ-012 CRD  out  DATA_W  read data, valid while rsp_valid.
REQ-013 rsp_valid  out  1  one-cycle completion pulse, reads and writes.
REQ-014 hit  out  1  qualifies rsp_valid: 1 = hit.
REQ-015 mem_req, mem_we  out  1  backing-memory request and write flag.
REQ-016 mem_adr  out  ADDR_W;  mem_wd  out  DATA_W  backing-memory address/data.
REQ-017 mem_ack  in  1;  mem_rd  in  DATA_W  backing-memory completion and read data.

Function
REQ-018 Fields: index = Adr[INDEX_W+1:2], tag = Adr[ADDR_W-1:INDEX_W+2]; per-line valid bit, tag, data.
REQ-019 States IDLE, FILL, WTHRU; request fields registered on acceptance.
REQ-020 MWR and MOE both high: treated as write.
REQ-021 Read hit: stay IDLE, next cycle rsp_valid=1, hit=1, CRD=line data (1-cycle latency).
REQ-022 Read miss: go FILL; mem_req=1, mem_we=0, mem_adr=Adr with [1:0]=0, held stable until mem_ack.
REQ-023 FILL with mem_ack: line written (valid=1, tag, mem_rd); same edge -> IDLE; next cycle rsp_valid=1, hit=0, CRD=mem_rd.
REQ-024 Write (hit or miss): line updated immediately (write-allocate), go WTHRU; mem_req=1, mem_we=1, mem_wd=MWD held until mem_ack.
REQ-025 WTHRU with mem_ack -> IDLE; next cycle rsp_valid=1, hit reports original lookup result.
REQ-026 mem_req deasserts the cycle after mem_ack; no new request in that cycle's response slot (req_ready=1 again in IDLE).
REQ-027 mem_ack outside FILL/WTHRU ignored.
REQ-028 flush in IDLE with no request: all valid bits cleared in one cycle; flush with a request accepted: flush first, request accepted next cycle; flush outside IDLE held off until IDLE.
REQ-029 CRD holds last value when rsp_valid=0.

Reset
REQ-030 rst clears all valid bits, state=IDLE, req_ready=1, rsp_valid=0, hit=0, CRD=0, mem_req=0, mem_we=0, mem_adr=0, mem_wd=0.
REQ-031 rst mid-FILL/WTHRU abandons transaction; mem_req=0 the next cycle; no rsp_valid emitted.
REQ-032 Tag/data arrays need no reset.

Configuration
REQ-033 Macro CACHE_STATS_EN defined: outputs hit_cnt, miss_cnt (32 bits each) count completed requests by hit, saturate at all-ones, cleared by rst, not by flush.
REQ-034 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-035 Package cache_pkg holds state enum (IDLE, FILL, WTHRU) and default parameter constants.
REQ-036 One sub-module cache_line_store: valid/tag/data arrays, combinational lookup, single write port, bulk valid clear.

Verification
REQ-037 After rst, read Adr=120 with mem_rd=0xA5A5_0001, ack after 3 cycles -> hit=0, CRD=0xA5A5_0001; repeat read -> 1-cycle hit, CRD=0xA5A5_0001, no mem_req.
REQ-038 Write Adr=110 MWD=1 -> mem_we=1, mem_adr=108, mem_wd=1 until ack; read Adr=110 -> hit=1, CRD=1.
REQ-039 Conflict: read 0x40 then 0x440 (same index, INDEX_W=4) -> both miss; re-read 0x40 -> miss.
REQ-040 flush after cached read of 120 -> re-read 120 misses; MWR=MOE=1 -> write performed.
REQ-041 rst asserted in FILL before mem_ack -> mem_req=0 next cycle, no rsp_valid, req_ready=1.
REQ-042 With CACHE_STATS_EN: REQ-037 sequence -> hit_cnt=1, miss_cnt=1.
